// File: rtl/mult_pipe_param.sv
// mult_pipe_param: parametrised, fully pipelined WIDTH x WIDTH multiplier.
// Stage 0 registers operand magnitudes and the result sign. Stages 1..N each
// fold one DIGIT-wide slice of |op2| into a running 2*WIDTH accumulator. A
// final register stage restores the sign. A global stall freezes every
// register, and a synchronous active-low reset discards in-flight operations.
module mult_pipe_param #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16,
  parameter int TAG_W = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_n,
  input  logic                 i_VALID,
  input  logic                 i_SIGNED,
  input  logic [TAG_W-1:0]     i_TAG,
  input  logic [WIDTH-1:0]     i_OP1,
  input  logic [WIDTH-1:0]     i_OP2,
  input  logic                 i_STALL,
  output logic                 o_VALID,
  output logic [TAG_W-1:0]     o_TAG,
  output logic [2*WIDTH-1:0]   o_RESULT
);

  localparam int N = WIDTH / DIGIT;

  if ((WIDTH % DIGIT) != 0 || N < 1) begin : g_param_check
    $error("mult_pipe_param: WIDTH must be a non-zero multiple of DIGIT");
  end

  // Index 0 is the input register; indices 1..N are the accumulate stages.
  logic [N:0]             valid;
  logic [N:0]             sign;
  logic [TAG_W-1:0]       tag  [0:N];

  // Magnitudes are only needed up to stage N-1. The last accumulate stage
  // consumes them without forwarding them.
  logic [WIDTH-1:0]       mag1 [0:N-1];
  logic [WIDTH-1:0]       mag2 [0:N-1];
  logic [2*WIDTH-1:0]     acc  [1:N];

  logic [WIDTH+DIGIT-1:0] pp_raw [1:N];
  logic [2*WIDTH-1:0]     pp     [1:N];

  logic                   neg1;
  logic                   neg2;
  logic [WIDTH-1:0]       abs1;
  logic [WIDTH-1:0]       abs2;

  // Take operand magnitudes. The most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    neg1 = i_SIGNED & i_OP1[WIDTH-1];
    neg2 = i_SIGNED & i_OP2[WIDTH-1];
    abs1 = neg1 ? -i_OP1 : i_OP1;
    abs2 = neg2 ? -i_OP2 : i_OP2;
  end

  // Partial product for each stage. mag2 is shifted down one digit per stage,
  // so the low DIGIT bits always hold the slice that the stage consumes.
  always_comb begin
    for (int k = 1; k <= N; k++) begin
      pp_raw[k] = {{DIGIT{1'b0}}, mag1[k-1]} * {{WIDTH{1'b0}}, mag2[k-1][DIGIT-1:0]};
      pp[k]     = (2*WIDTH)'(pp_raw[k]) << ((k-1)*DIGIT);
    end
  end

  // Pipeline registers for stages 0..N. Valid bits advance on every non-stalled
  // cycle. Data registers load only behind a valid operation.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      valid <= '0;
    end else if (!i_STALL) begin
      valid <= {valid[N-1:0], i_VALID};

      if (i_VALID) begin
        sign[0] <= neg1 ^ neg2;
        tag[0]  <= i_TAG;
        mag1[0] <= abs1;
        mag2[0] <= abs2;
      end

      for (int k = 1; k <= N; k++) begin
        if (valid[k-1]) begin
          sign[k] <= sign[k-1];
          tag[k]  <= tag[k-1];
        end
      end

      for (int k = 1; k <= N-1; k++) begin
        if (valid[k-1]) begin
          mag1[k] <= mag1[k-1];
          mag2[k] <= mag2[k-1] >> DIGIT;
        end
      end

      if (valid[0]) begin
        acc[1] <= pp[1];
      end
      for (int k = 2; k <= N; k++) begin
        if (valid[k-1]) begin
          acc[k] <= acc[k-1] + pp[k];
        end
      end
    end
  end

  // Output register: apply the sign and hold the last product between pulses.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      o_VALID  <= 1'b0;
      o_RESULT <= '0;
      o_TAG    <= '0;
    end else if (!i_STALL) begin
      o_VALID <= valid[N];
      if (valid[N]) begin
        o_RESULT <= sign[N] ? -acc[N] : acc[N];
        o_TAG    <= tag[N];
      end
    end
  end

endmodule
